// File: rtl/uop_packer_pkg.sv
// rtl/uop_packer_pkg.sv - shared uop constants for the packer and the 4-lane uop queue
//
// Purpose: one place for the uop width, the end-of-instruction flag position,
// the NOP encoding and the lane count, so packer and queue cannot disagree.
// Ports: none (package).
package uop_packer_pkg;

  localparam int UOP_W   = 39;
  localparam int EOI_BIT = 27;
  localparam int NLANES  = 4;

  // NOP is an empty uop that still closes its instruction (EOI set).
  localparam logic [UOP_W-1:0] NOP_UOP = 39'h0_0800_0000;

  // Overwrite the decoder's EOI bit with the packer's own view of it.
  function automatic logic [UOP_W-1:0] stamp_eoi(input logic [UOP_W-1:0] uop,
                                                 input logic             eoi);
    logic [UOP_W-1:0] r;
    r          = uop;
    r[EOI_BIT] = eoi;
    return r;
  endfunction

endpackage

// File: rtl/uop_packer.sv
// rtl/uop_packer.sv - packs a serial uop stream into 4-lane rows for the uop queue
//
// Purpose: collects uops one per cycle into a row, stamps EOI on the last uop
// of each instruction, and writes the whole row to the queue in one cycle.
// Every instruction starts in lane 0; long instructions spill into new rows.
// Ports:
//   CLK, RST          clock, synchronous active-high reset
//   flush             synchronous pipeline flush, drops partial and pending rows
//   uop_in/valid/last serial uop stream from the decoder, uop_ready back-pressure
//   Q_full            queue full (OR of lane FIFO full flags)
//   OUT_uop0..3       row lanes to the queue
//   WR_EN0..3         per-lane write strobes to the queue
module uop_packer
  import uop_packer_pkg::*;
(
  input  logic             CLK,
  input  logic             RST,
  input  logic             flush,
  input  logic [UOP_W-1:0] uop_in,
  input  logic             uop_valid,
  input  logic             uop_last,
  output logic             uop_ready,
  input  logic             Q_full,
  output logic [UOP_W-1:0] OUT_uop0,
  output logic [UOP_W-1:0] OUT_uop1,
  output logic [UOP_W-1:0] OUT_uop2,
  output logic [UOP_W-1:0] OUT_uop3,
  output logic             WR_EN0,
  output logic             WR_EN1,
  output logic             WR_EN2,
  output logic             WR_EN3
);

  logic [NLANES-1:0][UOP_W-1:0] row_q, row_d;
  logic [NLANES-1:0]            lane_valid_q, lane_valid_d;
  logic [1:0]                   lane_cnt_q, lane_cnt_d;
  logic                         pending_q, pending_d;

  logic       kill;
  logic       drain;
  logic       accept;
  logic [1:0] idx;
  logic [NLANES-1:0] wr_en;

  always_comb begin
    kill   = RST || flush;
    drain  = pending_q && !Q_full && !kill;
    // Depends only on state and Q_full, never on uop_valid: no loop with the decoder.
    uop_ready = (!pending_q || !Q_full) && !kill;
    accept = uop_valid && uop_ready;

    row_d        = row_q;
    lane_valid_d = lane_valid_q;
    lane_cnt_d   = lane_cnt_q;
    pending_d    = pending_q;
    idx          = lane_cnt_q;

    if (drain) begin
      lane_valid_d = '0;
      pending_d    = 1'b0;
    end

    if (accept) begin
      // A uop accepted alongside a drain always opens a fresh row at lane 0.
      idx               = drain ? 2'd0 : lane_cnt_q;
      row_d[idx]        = stamp_eoi(uop_in, uop_last);
      lane_valid_d[idx] = 1'b1;
      if (uop_last || idx == 2'd3) begin
        pending_d  = 1'b1;
        lane_cnt_d = 2'd0;
      end else begin
        lane_cnt_d = idx + 2'd1;
      end
    end

    if (kill) begin
      lane_valid_d = '0;
      lane_cnt_d   = 2'd0;
      pending_d    = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      row_q        <= '0;
      lane_valid_q <= '0;
      lane_cnt_q   <= 2'd0;
      pending_q    <= 1'b0;
    end else begin
      row_q        <= row_d;
      lane_valid_q <= lane_valid_d;
      lane_cnt_q   <= lane_cnt_d;
      pending_q    <= pending_d;
    end
  end

  // Lanes are driven to zero outside a drain so the queue never sees stale rows.
  always_comb begin
    wr_en    = drain ? lane_valid_q : '0;
    WR_EN0   = wr_en[0];
    WR_EN1   = wr_en[1];
    WR_EN2   = wr_en[2];
    WR_EN3   = wr_en[3];
    OUT_uop0 = drain ? row_q[0] : '0;
    OUT_uop1 = drain ? row_q[1] : '0;
    OUT_uop2 = drain ? row_q[2] : '0;
    OUT_uop3 = drain ? row_q[3] : '0;
  end

endmodule

// File: tb/tb_uop_packer.sv
// tb/tb_uop_packer.sv - scoreboard bench for uop_packer
module tb_uop_packer;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        flush = 1'b0;
  logic [38:0] uop_in = '0;
  logic        uop_valid = 1'b0;
  logic        uop_last = 1'b0;
  logic        uop_ready;
  logic        Q_full = 1'b0;
  logic [38:0] OUT_uop0, OUT_uop1, OUT_uop2, OUT_uop3;
  logic        WR_EN0, WR_EN1, WR_EN2, WR_EN3;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  typedef struct {
    int          at;
    logic [3:0]  wr;
    logic [38:0] lane [4];
  } exp_t;

  exp_t exp_q [$];

  uop_packer dut (
    .CLK(CLK), .RST(RST), .flush(flush),
    .uop_in(uop_in), .uop_valid(uop_valid), .uop_last(uop_last),
    .uop_ready(uop_ready), .Q_full(Q_full),
    .OUT_uop0(OUT_uop0), .OUT_uop1(OUT_uop1), .OUT_uop2(OUT_uop2), .OUT_uop3(OUT_uop3),
    .WR_EN0(WR_EN0), .WR_EN1(WR_EN1), .WR_EN2(WR_EN2), .WR_EN3(WR_EN3)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [38:0] act, input logic [38:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic push(input logic [3:0] wr, input logic [38:0] l0, input logic [38:0] l1,
                      input logic [38:0] l2, input logic [38:0] l3);
    exp_t e;
    e.at = cyc;
    e.wr = wr;
    e.lane[0] = l0; e.lane[1] = l1; e.lane[2] = l2; e.lane[3] = l3;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic put(input logic [38:0] u, input logic l);
    uop_in = u; uop_valid = 1'b1; uop_last = l;
    #1;
    chk("uop_ready_on_put", {38'b0, uop_ready}, 39'd1);
    tick();
    uop_valid = 1'b0; uop_last = 1'b0; uop_in = '0;
  endtask

  task automatic idle(input int n);
    uop_valid = 1'b0; uop_last = 1'b0;
    repeat (n) tick();
  endtask

  // Monitor: every cycle, a write must match the scoreboard head due this cycle.
  always @(negedge CLK) begin
    logic [3:0]  wr_act;
    logic [38:0] outs [4];
    exp_t e;
    wr_act  = {WR_EN3, WR_EN2, WR_EN1, WR_EN0};
    outs[0] = OUT_uop0; outs[1] = OUT_uop1; outs[2] = OUT_uop2; outs[3] = OUT_uop3;
    if (exp_q.size() > 0 && exp_q[0].at == cyc) begin
      e = exp_q.pop_front();
      chk("wr_en", {35'b0, wr_act}, {35'b0, e.wr});
      for (int k = 0; k < 4; k++)
        if (e.wr[k]) chk($sformatf("out_uop%0d", k), outs[k], e.lane[k]);
    end else if (exp_q.size() > 0 && exp_q[0].at < cyc) begin
      e = exp_q.pop_front();
      chk("missed_write", {35'b0, wr_act}, {35'b0, e.wr});
    end else if (wr_act != 4'b0000) begin
      chk("unexpected_write", {35'b0, wr_act}, 39'd0);
    end
  end

  initial begin
    // Reset / idle
    repeat (2) tick();
    RST = 1'b0;
    #1;
    chk("ready_after_reset", {38'b0, uop_ready}, 39'd1);
    chk("out0_after_reset", OUT_uop0, 39'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("ready_idle", {38'b0, uop_ready}, 39'd1);
    end

    // 3-uop instruction
    put(39'h11, 1'b0);
    put(39'h22, 1'b0);
    put(39'h33, 1'b1);
    push(4'b0111, 39'h11, 39'h22, 39'h0_0800_0033, 39'h0);
    idle(2);

    // 6-uop instruction spanning two rows; decoder-supplied bit 27 is ignored
    put(39'h101, 1'b0);
    put(39'h102, 1'b0);
    put(39'h0_0800_0103, 1'b0);
    put(39'h104, 1'b0);
    push(4'b1111, 39'h101, 39'h102, 39'h103, 39'h104);
    put(39'h105, 1'b0);
    put(39'h106, 1'b1);
    push(4'b0011, 39'h105, 39'h0_0800_0106, 39'h0, 39'h0);
    idle(2);

    // Back-to-back 1-uop instructions
    put(39'h0AA, 1'b1);
    push(4'b0001, 39'h0_0800_00AA, 39'h0, 39'h0, 39'h0);
    put(39'h0BB, 1'b1);
    push(4'b0001, 39'h0_0800_00BB, 39'h0, 39'h0, 39'h0);
    put(39'h0CC, 1'b1);
    push(4'b0001, 39'h0_0800_00CC, 39'h0, 39'h0, 39'h0);
    idle(2);

    // Backpressure: Q_full raised while the row is still filling
    put(39'h41, 1'b0);
    Q_full = 1'b1;
    put(39'h42, 1'b1);
    for (int i = 0; i < 5; i++) begin
      chk("ready_held_low", {38'b0, uop_ready}, 39'd0);
      tick();
    end
    Q_full = 1'b0;
    push(4'b0011, 39'h41, 39'h0_0800_0042, 39'h0, 39'h0);
    put(39'h51, 1'b1);
    push(4'b0001, 39'h0_0800_0051, 39'h0, 39'h0, 39'h0);
    idle(2);

    // Flush mid-instruction, with a valid uop offered during the flush
    put(39'h61, 1'b0);
    put(39'h62, 1'b0);
    flush = 1'b1;
    uop_in = 39'h63; uop_valid = 1'b1; uop_last = 1'b1;
    #1;
    chk("ready_in_flush", {38'b0, uop_ready}, 39'd0);
    tick();
    flush = 1'b0;
    idle(3);
    put(39'h71, 1'b1);
    push(4'b0001, 39'h0_0800_0071, 39'h0, 39'h0, 39'h0);
    idle(3);

    chk("scoreboard_empty", 39'(exp_q.size()), 39'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
